// File: rtl/ro_sampler_ctrl.sv
// Ring-oscillator bank sequencer for the TRNG: warms the oscillators up,
// samples the XOR of their synchronized outputs at a fixed rate, removes
// bias with von Neumann pairing, runs a repetition-count health test and
// packs the debiased bits into words delivered over valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | stopped; oscillators in even mode, all datapath cleared
// S_WARMUP | all oscillators in odd mode while they settle
// S_SAMPLE | divider running, raw bits sampled, debiased and packed
// S_HOLD   | complete word presented; divider frozen until accepted
// S_FAIL   | repetition test tripped; sticky until enable drops
module ro_sampler_ctrl #(
  parameter int NUM_RO     = 4,
  parameter int WORD_W     = 32,
  parameter int SAMPLE_DIV = 16,
  parameter int WARMUP_CYC = 64,
  parameter int REP_LIMIT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [NUM_RO-1:0] ro_out,
  output logic [NUM_RO-1:0] ro_ctrl,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              health_fail,
  output logic              busy
);

  localparam int WW = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  // Warm-up and divider are down-counters: loaded with N-1, terminal at 0.
  localparam logic [WW-1:0] WARM_LOAD = WW'(WARMUP_CYC - 1);
  localparam logic [DW-1:0] DIV_LOAD  = DW'(SAMPLE_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [RW-1:0] REP_TRIP  = RW'(REP_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_SAMPLE = 3'd2,
    S_HOLD   = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [NUM_RO-1:0] ro_meta_q, ro_sync_q;
  logic              raw;

  logic [WW-1:0]     warm_q, warm_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic              prev_q, prev_d;
  logic              pair_q, pair_d;
  logic              first_q, first_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [NUM_RO-1:0] pat_q, pat_d;

  logic              tick;
  logic              warm_done;
  logic [RW-1:0]     rep_next;
  logic              health_trip;
  logic              bit_ok;
  logic              word_done;

  // Two-flop synchronizer for the free-running oscillator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_meta_q <= '0;
      ro_sync_q <= '0;
    end else begin
      ro_meta_q <= ro_out;
      ro_sync_q <= ro_meta_q;
    end
  end

  assign raw = ^ro_sync_q;

  // Sample tick, health and debiasing conditions shared by FSM and datapath
  always_comb begin
    tick        = (state_q == S_SAMPLE) && (div_q == '0);
    warm_done   = (warm_q == '0);
    rep_next    = ((rep_q != '0) && (raw == prev_q)) ? rep_q + 1'b1 : RW'(1);
    health_trip = tick && (rep_next == REP_TRIP);
    // A differing pair always yields its first sample as the output bit.
    bit_ok      = tick && pair_q && (first_q != raw);
    word_done   = bit_ok && (bitcnt_q == BIT_LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping enable overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_WARMUP;
      S_WARMUP: if (warm_done) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (health_trip)    state_d = S_FAIL;
        else if (word_done) state_d = S_HOLD;
      end
      S_HOLD:   if (rnd_ready) state_d = S_SAMPLE;
      S_FAIL:   state_d = S_FAIL;
      default:  state_d = S_IDLE;
    endcase
    if (!enable) state_d = S_IDLE;
  end

  // Outputs decoded from the registered state only (no path from rnd_ready)
  always_comb begin
    ro_ctrl     = '0;
    rnd_valid   = 1'b0;
    health_fail = 1'b0;
    busy        = 1'b0;
    case (state_q)
      S_WARMUP: begin
        ro_ctrl = '1;
        busy    = 1'b1;
      end
      S_SAMPLE: begin
        ro_ctrl = pat_q;
        busy    = 1'b1;
      end
      S_HOLD: begin
        ro_ctrl   = pat_q;
        busy      = 1'b1;
        rnd_valid = 1'b1;
      end
      S_FAIL:  health_fail = 1'b1;
      default: ;
    endcase
  end

  assign rnd_data = data_q;

  // Datapath next-state: counters, debiaser, shift register, ctrl pattern
  always_comb begin
    warm_d   = warm_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    rep_d    = rep_q;
    prev_d   = prev_q;
    pair_d   = pair_q;
    first_d  = first_q;
    data_d   = data_q;
    pat_d    = pat_q;
    case (state_q)
      S_WARMUP: begin
        if (!warm_done) warm_d = warm_q - 1'b1;
        div_d    = DIV_LOAD;
        pair_d   = 1'b0;
        bitcnt_d = '0;
        pat_d    = '0;
      end
      S_SAMPLE: begin
        if (tick) begin
          div_d  = DIV_LOAD;
          rep_d  = rep_next;
          prev_d = raw;
          pair_d = ~pair_q;
          if (!pair_q) first_d = raw;
          if (bit_ok) begin
            data_d   = {data_q[WORD_W-2:0], first_q};
            bitcnt_d = bitcnt_q + 1'b1;
          end
          if (word_done && !health_trip) pat_d = pat_q + 1'b1;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (rnd_ready) begin
          bitcnt_d = '0;
          div_d    = DIV_LOAD;
        end
      end
      default: ;
    endcase
    // Entering or staying in IDLE discards any partial or pending word.
    if (state_d == S_IDLE) begin
      warm_d   = WARM_LOAD;
      div_d    = DIV_LOAD;
      bitcnt_d = '0;
      rep_d    = '0;
      prev_d   = 1'b0;
      pair_d   = 1'b0;
      first_d  = 1'b0;
      data_d   = '0;
      pat_d    = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q   <= WARM_LOAD;
      div_q    <= DIV_LOAD;
      bitcnt_q <= '0;
      rep_q    <= '0;
      prev_q   <= 1'b0;
      pair_q   <= 1'b0;
      first_q  <= 1'b0;
      data_q   <= '0;
      pat_q    <= '0;
    end else begin
      warm_q   <= warm_d;
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      rep_q    <= rep_d;
      prev_q   <= prev_d;
      pair_q   <= pair_d;
      first_q  <= first_d;
      data_q   <= data_d;
      pat_q    <= pat_d;
    end
  end

endmodule

// File: tb/tb_ro_sampler_ctrl.sv
// Bench for ro_sampler_ctrl: directed word patterns from a vector table,
// hand-written corner sequences, and randomized oscillator streams checked
// cycle by cycle against a timestamp-level model of the sampler.
module tb_ro_sampler_ctrl;

  localparam int NRO = 2;
  localparam int WW  = 8;
  localparam int DIV = 4;
  localparam int WRM = 8;
  localparam int REP = 6;
  localparam int N   = 360;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [NRO-1:0] ro_out;
  logic [NRO-1:0] ro_ctrl;
  logic [WW-1:0]  rnd_data;
  logic           rnd_valid;
  logic           rnd_ready;
  logic           health_fail;
  logic           busy;

  int total = 0;
  int bad   = 0;

  ro_sampler_ctrl #(
    .NUM_RO(NRO), .WORD_W(WW), .SAMPLE_DIV(DIV), .WARMUP_CYC(WRM), .REP_LIMIT(REP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ro_out(ro_out),
    .ro_ctrl(ro_ctrl), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .health_fail(health_fail), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pat;     // pat[j] = raw value of sample j within one period
    int         period;
    int         nticks;  // samples needed to complete the word
    logic [7:0] word;
  } vec_t;

  vec_t vecs[5];

  logic [1:0] ro_drv[N];
  logic [4:0] exp_st[N];
  logic [7:0] exp_w[N];
  bit         exp_v[N];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] status();
    return {busy, rnd_valid, health_fail, ro_ctrl};
  endfunction

  // Hold one raw value on the oscillator inputs for ncyc cycles
  task automatic drive_sample(input logic r, input int ncyc);
    logic b;
    b = 1'($urandom_range(0, 1));
    ro_out = {b, b ^ r};
    repeat (ncyc) step();
  endtask

  // From any state: return to IDLE, enable, and stop in the first SAMPLE cycle
  task automatic start_session();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    repeat (WRM + 1) step();
  endtask

  // Raw stream per cycle and expected per-cycle outputs from sampling rules
  task automatic build_model(input bit lively);
    int  nxt, words, nb, rep, p;
    bit  failed, hf, fb, prv, r, b;
    logic [7:0] w;
    bit  rr[N];
    for (int c = 0; c < N; c++) begin
      if (lively && c >= 4) rr[c] = rr[c-4] ^ ($urandom_range(0, 3) != 0);
      else                  rr[c] = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      ro_drv[c] = {b, b ^ rr[c]};
      exp_st[c] = '0;
      exp_v[c]  = 1'b0;
      exp_w[c]  = '0;
    end
    for (int c = 1; c <= WRM; c++) exp_st[c] = 5'b1_0_0_11;
    failed = 0; hf = 0; fb = 0; prv = 0; w = '0;
    words = 0; nb = 0; rep = 0;
    // enable seen at edge 1, SAMPLE from cycle WRM+1, first tick DIV edges later
    nxt = WRM + 1 + DIV;
    for (int c = WRM + 1; c < N; c++) begin
      if (!failed && c == nxt) begin
        r   = ^ro_drv[c-3];   // two sync flops plus the capture edge
        rep = (rep > 0 && r == prv) ? rep + 1 : 1;
        prv = r;
        nxt = c + DIV;
        if (rep == REP) failed = 1;
        else if (!hf) begin
          hf = 1;
          fb = r;
        end else begin
          hf = 0;
          if (fb != r) begin
            w = {w[6:0], fb};
            nb++;
            if (nb == WW) begin
              nb = 0;
              words++;
              exp_v[c] = 1'b1;
              exp_w[c] = w;
              nxt = c + 1 + DIV;  // one HOLD cycle, handshake, then a fresh divider
            end
          end
        end
      end
      p = words % 4;
      if (failed) exp_st[c] = 5'b0_0_1_00;
      else        exp_st[c] = {1'b1, exp_v[c], 1'b0, 2'(p)};
    end
  endtask

  initial begin
    vecs[0] = '{pat: 8'h01, period: 2, nticks: 16, word: 8'hFF};
    vecs[1] = '{pat: 8'h4B, period: 8, nticks: 32, word: 8'h55};
    vecs[2] = '{pat: 8'h02, period: 2, nticks: 16, word: 8'h00};
    vecs[3] = '{pat: 8'h09, period: 4, nticks: 16, word: 8'hAA};
    vecs[4] = '{pat: 8'h25, period: 6, nticks: 16, word: 8'hDB};

    rst_n = 1'b0; enable = 1'b0; rnd_ready = 1'b0; ro_out = '0;
    #1;
    chk("reset_outputs", {ro_ctrl, rnd_data, rnd_valid, health_fail, busy}, '0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_outputs", {ro_ctrl, rnd_data, rnd_valid, health_fail, busy}, '0);

    // Vector table: one fresh word per entry
    foreach (vecs[i]) begin
      rnd_ready = 1'b0;
      start_session();
      chk("vec_entry_ctrl", ro_ctrl, 2'b00);
      for (int k = 0; k < vecs[i].nticks - 1; k++)
        drive_sample(vecs[i].pat[k % vecs[i].period], DIV);
      drive_sample(vecs[i].pat[(vecs[i].nticks - 1) % vecs[i].period], DIV - 1);
      chk("vec_valid_early", rnd_valid, 1'b0);
      step();
      chk("vec_valid", rnd_valid, 1'b1);
      chk("vec_word", rnd_data, vecs[i].word);
      chk("vec_ctrl", ro_ctrl, 2'b01);
      rnd_ready = 1'b1;
      step();
      chk("vec_valid_drop", rnd_valid, 1'b0);
    end

    // Asynchronous reset mid-SAMPLE, then restart with enable held high
    rnd_ready = 1'b1;
    start_session();
    repeat (4) drive_sample(1'b1, DIV);
    drive_sample(1'b0, 2);
    chk("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {ro_ctrl, rnd_data, rnd_valid, health_fail, busy}, '0);
    step();
    rst_n = 1'b1;
    chk("post_reset_idle", busy, 1'b0);
    for (int i = 0; i < WRM; i++) begin
      step();
      chk("warmup_busy_ctrl", {busy, ro_ctrl}, 3'b1_11);
    end
    step();
    chk("sample_entry_ctrl", {busy, ro_ctrl}, 3'b1_00);

    // Backpressure: word held stable while ready is low, oscillators keep toggling
    rnd_ready = 1'b0;
    start_session();
    for (int k = 0; k < 16; k++) drive_sample((k % 2) == 0, DIV);
    chk("bp_valid", rnd_valid, 1'b1);
    chk("bp_word", rnd_data, 8'hFF);
    for (int i = 0; i < 50; i++) begin
      ro_out = 2'($urandom_range(0, 3));
      step();
      chk("bp_hold", {rnd_valid, rnd_data, ro_ctrl}, {1'b1, 8'hFF, 2'b01});
    end
    rnd_ready = 1'b1;
    step();
    chk("bp_valid_drop", rnd_valid, 1'b0);
    for (int k = 0; k < 15; k++) drive_sample((k % 2) == 1, DIV);
    drive_sample(1'b1, DIV - 1);
    chk("bp_second_early", rnd_valid, 1'b0);
    rnd_ready = 1'b0;
    step();
    chk("bp_second_valid", rnd_valid, 1'b1);
    chk("bp_second_word", rnd_data, 8'h00);
    chk("bp_second_ctrl", ro_ctrl, 2'b10);
    enable = 1'b0;
    step();
    chk("pending_dropped", {rnd_valid, busy, rnd_data}, '0);

    // Health: runs of five are tolerated, the sixth identical sample trips
    rnd_ready = 1'b1;
    start_session();
    repeat (5) drive_sample(1'b0, DIV);
    drive_sample(1'b1, DIV);
    repeat (5) drive_sample(1'b0, DIV);
    chk("health_run5", {health_fail, busy}, 2'b01);
    drive_sample(1'b0, DIV);
    chk("health_trip", {health_fail, rnd_valid, ro_ctrl, busy}, 5'b1_0_00_0);
    repeat (3) step();
    chk("health_sticky", health_fail, 1'b1);
    enable = 1'b0;
    step();
    chk("health_clear", {health_fail, busy}, 2'b00);

    // Abort after five bits; the next word must be entirely fresh
    start_session();
    for (int k = 0; k < 10; k++) drive_sample((k % 2) == 0, DIV);
    chk("abort_partial", rnd_data, 8'h1F);
    enable = 1'b0;
    step();
    chk("abort_cleared", {busy, rnd_data}, '0);
    start_session();
    for (int k = 0; k < 16; k++) drive_sample((k % 2) == 1, DIV);
    chk("abort_fresh_valid", rnd_valid, 1'b1);
    chk("abort_fresh_word", rnd_data, 8'h00);
    chk("abort_fresh_ctrl", ro_ctrl, 2'b01);

    // Randomized streams against the model
    for (int run = 0; run < 4; run++) begin
      rnd_ready = 1'b1;
      enable = 1'b0;
      step();
      step();
      build_model(run % 2 == 1);
      for (int c = 0; c < N; c++) begin
        ro_out = ro_drv[c];
        enable = 1'b1;
        chk("rand_status", status(), exp_st[c]);
        if (exp_v[c]) chk("rand_word", rnd_data, exp_w[c]);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
